// File: rtl/paralelo_serialtx.sv
// paralelo_serialtx: byte-wide valid/ready to MSB-first serial stream with comma sync/idle framing
module paralelo_serialtx #(
  parameter logic [7:0] COMMA  = 8'hBC,
  parameter int         N_SYNC = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       active_out
);
  typedef enum logic {SYNC, ACTIVE} state_t;
  localparam logic [3:0] NS = 4'(N_SYNC);
  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] sync_cnt_q, sync_cnt_d;
  logic [7:0] shift_q, shift_d, frame_byte;
  logic       data_out_q, data_out_d, ready_q, ready_d, active_q, active_d;
  logic       frame_start, go_active;
  always_comb begin
    frame_start = bit_cnt_q == 3'd0;
    go_active   = state_q == SYNC && sync_cnt_q == NS;
    // ready_q is only ever high in the cycle ending at a frame start, so it doubles as the accept gate
    frame_byte  = (ready_q && valid_in) ? data_in : COMMA;
    bit_cnt_d   = bit_cnt_q + 3'd1;
    sync_cnt_d  = (frame_start && state_q == SYNC && !go_active) ? sync_cnt_q + 4'd1 : sync_cnt_q;
    state_d     = (frame_start && go_active) ? ACTIVE : state_q;
    active_d    = state_d == ACTIVE;
    shift_d     = frame_start ? {frame_byte[6:0], 1'b0} : {shift_q[6:0], 1'b0};
    data_out_d  = frame_start ? frame_byte[7] : shift_q[7];
    ready_d     = bit_cnt_q == 3'd7 && (state_q == ACTIVE || sync_cnt_q == NS);
  end
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q    <= SYNC;
      bit_cnt_q  <= 3'd0;
      sync_cnt_q <= 4'd0;
      shift_q    <= 8'd0;
      data_out_q <= 1'b0;
      ready_q    <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sync_cnt_q <= sync_cnt_d;
      shift_q    <= shift_d;
      data_out_q <= data_out_d;
      ready_q    <= ready_d;
      active_q   <= active_d;
    end
  end
  assign data_out   = data_out_q;
  assign ready_out  = ready_q;
  assign active_out = active_q;
endmodule

// File: tb/tb_paralelo_serialtx.sv
// tb_paralelo_serialtx: directed + randomized frames checked against an edge-indexed framing model
module tb_paralelo_serialtx;
  localparam logic [7:0] COMMA  = 8'hBC;
  localparam int         N_SYNC = 4;
  logic       clk_32f = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'd0;
  logic       valid_in = 1'b0;
  logic       ready_out, data_out, active_out;
  int         tests = 0;
  int         fails = 0;
  int         e = -1;
  logic [7:0] fb = 8'd0;
  logic [7:0] rx_sr = 8'd0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic       exp_d, exp_r, exp_a;
  paralelo_serialtx #(.COMMA(COMMA), .N_SYNC(N_SYNC)) dut (
    .clk_32f(clk_32f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .data_out(data_out), .active_out(active_out)
  );
  always #5 clk_32f = ~clk_32f;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s edge=%0d observed=%h expected=%h", tag, e, obs, exp);
    end
  endtask
  // Expected outputs derive from the edge index since reset release: frame k = e/8, bit 7-(e%8)
  task automatic step();
    logic       r, v;
    logic [7:0] d;
    @(posedge clk_32f);
    r = reset;
    v = valid_in;
    d = data_in;
    if (r) begin
      e = -1;
      exp_d = 1'b0;
      exp_r = 1'b0;
      exp_a = 1'b0;
      rx_q.delete();
      tx_q.delete();
    end else begin
      e++;
      if (e % 8 == 0) begin
        fb = (e / 8 >= N_SYNC && v) ? d : COMMA;
        if (e / 8 >= N_SYNC && v) tx_q.push_back(d);
      end
      exp_d = fb[7 - e % 8];
      exp_r = ((e + 1) % 8 == 0) && ((e + 1) / 8 >= N_SYNC);
      exp_a = e >= 8 * N_SYNC;
    end
    #1;
    chk("data_out", {7'd0, data_out}, {7'd0, exp_d});
    chk("ready_out", {7'd0, ready_out}, {7'd0, exp_r});
    chk("active_out", {7'd0, active_out}, {7'd0, exp_a});
    if (!r) begin
      rx_sr = {rx_sr[6:0], data_out};
      if (e % 8 == 7 && rx_sr != COMMA) rx_q.push_back(rx_sr);
    end
  endtask
  task automatic frame(input logic [7:0] b, input int vpos);
    for (int i = 0; i < 8; i++) begin
      valid_in = (i == vpos);
      data_in  = (i == vpos) ? b : 8'($urandom);
      step();
    end
  endtask
  initial begin
    logic [7:0] b;
    logic [7:0] lb[3];
    lb[0] = 8'h12;
    lb[1] = 8'h34;
    lb[2] = 8'h56;
    for (int i = 0; i < 3; i++) step();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) step();
    valid_in = 1'b1;
    data_in  = 8'hA5;
    for (int i = 0; i < 16; i++) step();
    frame(8'h00, 0);
    frame(8'hFF, 0);
    frame(8'h3C, 0);
    frame(8'h55, 3);
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom);
      if (b == COMMA) b = 8'h00;
      frame(b, $urandom_range(0, 2));
    end
    valid_in = 1'b1;
    data_in  = 8'h81;
    step();
    valid_in = 1'b0;
    for (int i = 0; i < 3; i++) step();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) step();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      valid_in = 1'b1;
      data_in  = 8'($urandom);
      step();
    end
    for (int k = 0; k < 3; k++) frame(lb[k], 0);
    frame(8'h00, 8);
    chk("rx_count", 8'(rx_q.size()), 8'd3);
    for (int k = 0; k < 3; k++) chk("rx_byte", (k < rx_q.size()) ? rx_q[k] : 8'hxx, lb[k]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
